// File: rtl/tio_sync_pkg.sv
// Shared types and widths for the sysclk-domain sync sequencer.
package tio_sync_pkg;

  localparam int unsigned OFFSET_W   = 8;
  localparam int unsigned SYNC_CNT_W = 16;
  localparam int unsigned EXT_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EXT  = 2'd2
  } state_e;

endpackage

// File: rtl/tio_sync_gen.sv
// Sync sequencer: delays a TURF sync request, realigns sequence phase and
// sysclk counter, and optionally emits the external SURF clock-sync pulse.
module tio_sync_gen
  import tio_sync_pkg::*;
#(
  parameter int unsigned SEQ_LEN        = 8,
  parameter int unsigned EXT_SYNC_WIDTH = 4
) (
  input  logic                        sys_clk_i,
  input  logic                        sys_rst_n_i,
  input  logic [7:0]                  sync_offset_i,
  input  logic                        en_ext_sync_i,
  input  logic [7:0]                  clk_offset_i,
  input  logic                        sync_req_i,
  output logic                        sync_busy_o,
  output logic                        req_ignored_o,
  output logic                        sync_done_o,
  output logic [$clog2(SEQ_LEN)-1:0]  seq_phase_o,
  output logic                        seq_start_o,
  output logic [7:0]                  sysclk_cnt_o,
  output logic                        ext_sync_o,
  output logic [15:0]                 sync_count_o
);

  localparam int unsigned PH_W = $clog2(SEQ_LEN);

  state_e                state_q, state_d;
  logic [OFFSET_W-1:0]   wait_q, wait_d;
  logic [EXT_CNT_W-1:0]  ext_cnt_q, ext_cnt_d;
  logic [OFFSET_W-1:0]   clk_off_q;
  logic                  en_q;
  logic                  capture;
  logic                  apply;
  logic                  done_d;

  // State register
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      ext_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ext_cnt_q <= ext_cnt_d;
    end
  end

  // Next state; done is predicted one cycle early so it lands in the apply cycle
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    ext_cnt_d = ext_cnt_q;
    capture   = 1'b0;
    apply     = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync_req_i) begin
          capture = 1'b1;
          wait_d  = sync_offset_i;
          state_d = WAIT;
          done_d  = (sync_offset_i == OFFSET_W'(0));
        end
      end
      WAIT: begin
        if (wait_q == OFFSET_W'(0)) begin
          apply = 1'b1;
          if (en_q) begin
            state_d   = EXT;
            ext_cnt_d = EXT_CNT_W'(EXT_SYNC_WIDTH - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          wait_d = wait_q - OFFSET_W'(1);
          done_d = (wait_q == OFFSET_W'(1));
        end
      end
      EXT: begin
        if (ext_cnt_q == EXT_CNT_W'(0)) begin
          state_d = IDLE;
        end else begin
          ext_cnt_d = ext_cnt_q - EXT_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs, captured request parameters and free-running counters
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      clk_off_q     <= '0;
      en_q          <= 1'b0;
      sync_busy_o   <= 1'b0;
      req_ignored_o <= 1'b0;
      sync_done_o   <= 1'b0;
      ext_sync_o    <= 1'b0;
      seq_phase_o   <= '0;
      sysclk_cnt_o  <= '0;
      sync_count_o  <= '0;
    end else begin
      if (capture) begin
        clk_off_q <= clk_offset_i;
        en_q      <= en_ext_sync_i;
      end
      sync_busy_o   <= (state_d != IDLE);
      req_ignored_o <= sync_req_i && (state_q != IDLE);
      sync_done_o   <= done_d;
      ext_sync_o    <= (state_d == EXT);
      if (apply) begin
        seq_phase_o  <= '0;
        sysclk_cnt_o <= clk_off_q;
        if (sync_count_o != '1) begin
          sync_count_o <= sync_count_o + SYNC_CNT_W'(1);
        end
      end else begin
        seq_phase_o  <= seq_phase_o + PH_W'(1);
        sysclk_cnt_o <= sysclk_cnt_o + OFFSET_W'(1);
      end
    end
  end

  assign seq_start_o = (seq_phase_o == PH_W'(0));

endmodule
